// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci LFSR with multi-bit advance, seed load,
// zero-lockup protection and period tracking via wrap and sub-step count.
module lfsr_gen #(
   parameter int unsigned            WIDTH    = 16,
   parameter logic [WIDTH-1:0]       TAPS     = 'h002D,
   parameter logic [WIDTH-1:0]       SEED     = 'hECEB,
   parameter int unsigned            OUT_BITS = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                load,
   input  logic [WIDTH-1:0]    load_value,
   output logic [OUT_BITS-1:0] rand_bits,
   output logic [WIDTH-1:0]    shift_reg,
   output logic                valid,
   output logic                zero_fix,
   output logic                wrap,
   output logic [WIDTH-1:0]    step_count
);

   // Elaboration-time guards on the parameter space.
   if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $fatal(1, "lfsr_gen: WIDTH must be in 2..32");
   end
   if (OUT_BITS < 1 || OUT_BITS > WIDTH) begin : g_bad_out_bits
      $fatal(1, "lfsr_gen: OUT_BITS must be in 1..WIDTH");
   end
   if (SEED == '0) begin : g_bad_seed
      $fatal(1, "lfsr_gen: SEED must be nonzero");
   end

   logic [WIDTH-1:0]    state_q, state_d;
   logic [WIDTH-1:0]    origin_q, origin_d;
   logic [WIDTH-1:0]    cnt_q, cnt_d;
   logic [OUT_BITS-1:0] rand_q, rand_d;
   logic                valid_q, valid_d;
   logic                zfix_q, zfix_d;
   logic                wrap_q, wrap_d;

   logic [WIDTH-1:0]    adv_state;
   logic [OUT_BITS-1:0] adv_bits;
   logic                adv_hit;
   logic [WIDTH-1:0]    adv_cnt;
   logic [WIDTH-1:0]    ld_val;

   // Chain OUT_BITS sub-steps; remember the first one landing on origin.
   always_comb begin
      adv_state = state_q;
      adv_bits  = '0;
      adv_hit   = 1'b0;
      adv_cnt   = cnt_q + WIDTH'(OUT_BITS);
      for (int k = 0; k < int'(OUT_BITS); k++) begin
         adv_bits[k] = adv_state[0];
         adv_state   = {^(adv_state & TAPS), adv_state[WIDTH-1:1]};
         if (!adv_hit && adv_state == origin_q) begin
            adv_hit = 1'b1;
            adv_cnt = WIDTH'(int'(OUT_BITS) - 1 - k);
         end
      end
   end

   // A zero seed would lock the register, so substitute SEED.
   assign ld_val = (load_value == '0) ? SEED : load_value;

   // Next-state selection: load beats advance, otherwise hold.
   always_comb begin
      state_d  = state_q;
      origin_d = origin_q;
      cnt_d    = cnt_q;
      rand_d   = rand_q;
      valid_d  = 1'b0;
      zfix_d   = 1'b0;
      wrap_d   = 1'b0;
      if (load) begin
         state_d  = ld_val;
         origin_d = ld_val;
         cnt_d    = '0;
         zfix_d   = (load_value == '0);
      end else if (en) begin
         state_d = adv_state;
         rand_d  = adv_bits;
         cnt_d   = adv_cnt;
         valid_d = 1'b1;
         wrap_d  = adv_hit;
      end
   end

   // State registers with synchronous reset overriding everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= SEED;
         origin_q <= SEED;
         cnt_q    <= '0;
         rand_q   <= '0;
         valid_q  <= 1'b0;
         zfix_q   <= 1'b0;
         wrap_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         origin_q <= origin_d;
         cnt_q    <= cnt_d;
         rand_q   <= rand_d;
         valid_q  <= valid_d;
         zfix_q   <= zfix_d;
         wrap_q   <= wrap_d;
      end
   end

   assign rand_bits  = rand_q;
   assign shift_reg  = state_q;
   assign valid      = valid_q;
   assign zero_fix   = zfix_q;
   assign wrap       = wrap_q;
   assign step_count = cnt_q;

endmodule

// File: doc/lfsr_gen.md
Name: lfsr_gen

Overview:
Parametrised Fibonacci LFSR pseudo-random generator, the successor to the fixed 16-bit single-bit LFSR. Width, tap mask, seed and bits-per-advance are configurable. Adds runtime seed load with all-zero lock-up protection, a per-advance valid strobe, and period tracking through a wrap pulse and a sub-step counter. Used as a stimulus and random source in benches and datapaths.

Parameters:
WIDTH, 16, state width; legal range 2..32.
TAPS, 'h002D, feedback mask; state[i] is XORed into feedback when TAPS[i]=1. The default selects bits 0, 2, 3, 5.
SEED, 'hECEB, reset and substitute state. Must be nonzero; elaboration fatal if zero.
OUT_BITS, 1, single-bit sub-steps per advance; legal range 1..WIDTH.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
en  in  1  advance request, sampled each posedge
load  in  1  load load_value as new state and origin
load_value  in  WIDTH  seed to load
rand_bits  out  OUT_BITS  output bits of the last advance; bit k is from sub-step k (k=0 first)
shift_reg  out  WIDTH  current state
valid  out  1  one-cycle pulse: rand_bits/shift_reg were updated by an advance
zero_fix  out  1  one-cycle pulse: a zero load was replaced by SEED
wrap  out  1  one-cycle pulse: state returned to origin during the last advance
step_count  out  WIDTH  sub-steps since origin, modulo 2^WIDTH

Behaviour:
- Sub-step on state s:
  - fb = ^(s & TAPS)
  - out = s[0]
  - s' = {fb, s[WIDTH-1:1]} (shift right, feedback into MSB)
- Advance: OUT_BITS chained sub-steps, all combinational within one cycle.
  - rand_bits[k] = out of sub-step k.
  - shift_reg takes the state after the last sub-step.
- Priority at each posedge: rst > load > en > hold.
- Reset (synchronous, rst=1 at posedge):
  - shift_reg=SEED, origin=SEED
  - rand_bits=0, valid=0, zero_fix=0, wrap=0, step_count=0
  - A reset mid-operation discards any pending en or load.
- Load (load=1, rst=0):
  - state and origin <= load_value, or SEED if load_value==0.
  - zero_fix=1 for one cycle in the zero case.
  - step_count=0, valid=0, wrap=0, rand_bits held.
  - en is ignored that cycle; no advance occurs.
- Advance (en=1, load=0, rst=0):
  - Results are visible one cycle after the sampling edge.
  - valid=1 for that one cycle only.
  - en held high advances every cycle, and valid stays high.
- Hold (en=0): state, rand_bits, step_count unchanged; valid, wrap, zero_fix all 0.
- Wrap detection is per sub-step. Let j (1-based) be the first sub-step whose resulting state equals origin:
  - wrap=1
  - step_count <= OUT_BITS-j
  - Otherwise step_count <= step_count+OUT_BITS (mod 2^WIDTH).
- With a primitive TAPS polynomial the period is 2^WIDTH-1 sub-steps. The all-zero state is unreachable from any legal load or reset.
- The outputs valid, wrap and zero_fix are registered; no combinational path from inputs to outputs.

Test Plan:
1. Reset test (defaults): rst held 4 cycles, then released.
   - Expect shift_reg=ECEB, valid=0, step_count=0.
   - Then pulse en 1 cycle: next cycle shift_reg=F675, rand_bits=1, valid=1, step_count=1.
2. OUT_BITS=2 from reset: one en pulse.
   - Expect shift_reg=FB3A, rand_bits=2'b11, step_count=2.
3. Full period (defaults): 65535 en pulses with random 0-3 idle gaps between them, each state checked against a model.
   - On the final advance: shift_reg=ECEB, wrap=1, step_count=0.
   - No earlier wrap.
4. load=1 with load_value=0000.
   - Expect shift_reg=ECEB, zero_fix=1 for one cycle, step_count=0, valid=0.
5. load=1 with load_value=1234 and en=1 in the same cycle.
   - Expect shift_reg=1234, valid=0.
   - Next en: shift_reg=091A, rand_bits=0.
6. rst asserted while en=1 mid-stream (state != SEED).
   - Next cycle: shift_reg=ECEB, valid=0, wrap=0, step_count=0.
